// File: rtl/facto_master.sv
// facto_master: bus initiator that runs one factorial operation on a memory-mapped slave per request
module facto_master #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [63:0] req_operand,
  input  logic        use_intr,
  output logic        busy,
  output logic        res_valid,
  output logic        err,
  output logic [63:0] res_h,
  output logic [63:0] res_l,
  output logic        m_sel,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout,
  input  logic [63:0] m_din,
  input  logic        interrupt
);
  typedef enum logic [3:0] {
    IDLE, W_OPND, W_INTR, W_START, WAIT, R_H, R_L, W_CLR, W_CLR0A, W_CLR0B, FIN
  } state_t;
  state_t state, state_nx;
  logic gap, gap_nx, intr_mode, done_q, to_q, poll, hit, tmo, sel, wr;
  logic [63:0] opnd, dat;
  logic [15:0] wcnt;
  logic [7:0] pc, off;
  assign poll = state == WAIT && !intr_mode && pc == 8'd0;
  assign hit = done_q || (intr_mode && interrupt);
  assign tmo = wcnt >= 16'(TIMEOUT - 1);
  always_comb begin
    off = 8'h00;
    wr = 1'b0;
    dat = 64'd0;
    sel = !gap;
    case (state)
      W_OPND: begin off = 8'h20; wr = 1'b1; dat = opnd; end
      W_INTR: begin off = 8'h18; wr = 1'b1; dat = {63'd0, intr_mode}; end
      W_START: begin off = 8'h00; wr = 1'b1; dat = 64'd1; end
      WAIT: begin off = 8'h10; sel = poll; end
      R_H: off = 8'h28;
      R_L: off = 8'h30;
      W_CLR: begin off = 8'h08; wr = 1'b1; dat = 64'd1; end
      W_CLR0A: begin off = 8'h08; wr = 1'b1; end
      W_CLR0B: begin off = 8'h00; wr = 1'b1; end
      default: sel = 1'b0;
    endcase
  end
  assign m_sel = sel;
  assign m_wr = sel & wr;
  assign m_addr = sel ? BASE_ADDR + {8'h00, off} : 16'h0000;
  assign m_dout = sel ? dat : 64'd0;
  assign busy = state != IDLE;
  assign res_valid = state == FIN && !to_q;
  assign err = state == FIN && to_q;
  always_comb begin
    state_nx = state;
    gap_nx = 1'b0;
    case (state)
      IDLE: state_nx = req ? W_OPND : IDLE;
      WAIT: state_nx = hit ? R_H : (tmo && !poll) ? W_CLR : WAIT;
      FIN: state_nx = IDLE;
      default: begin
        gap_nx = !gap;
        state_nx = gap ? state_t'(state + 4'd1) : state;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      gap <= 1'b0;
      opnd <= 64'd0;
      intr_mode <= 1'b0;
      done_q <= 1'b0;
      to_q <= 1'b0;
      wcnt <= 16'd0;
      pc <= 8'd0;
      res_h <= 64'd0;
      res_l <= 64'd0;
    end else begin
      state <= state_nx;
      gap <= gap_nx;
      if (state == IDLE && req) begin
        opnd <= req_operand;
        intr_mode <= use_intr;
        to_q <= 1'b0;
      end
      done_q <= poll && m_din[0];
      wcnt <= state != WAIT ? 16'd0 : wcnt + {15'd0, wcnt != 16'(TIMEOUT)};
      pc <= state != WAIT ? 8'd0 : poll ? 8'(POLL_GAP) : pc - 8'd1;
      if (state == WAIT && state_nx == W_CLR) to_q <= 1'b1;
      if (state == R_H && !gap) res_h <= m_din;
      if (state == R_L && !gap) res_l <= m_din;
    end
endmodule

// File: doc/facto_master.md
Name: facto_master

Overview:
- Bus initiator that drives a memory-mapped factorial slave over the single-cycle s_sel/s_wr/s_addr bus on behalf of a local requester.
- Accepts one operand request, then:
  - programs the slave's OPERAND and INTR_EN registers,
  - sets OP_START,
  - waits for completion by interrupt or by polling OP_DONE,
  - reads RESULT_H and RESULT_L,
  - issues OP_CLEAR.
- Sits between control logic (or a testbench sequencer) and the slave, and returns the 128-bit result with a valid pulse.

Parameters:
- BASE_ADDR, 16'h0000, slave base address; register offsets are added to it.
- POLL_GAP, 4, idle cycles between OP_DONE polling reads (1..255).
- TIMEOUT, 4096, maximum cycles spent in the wait phase before abort (1..65535).

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  1  start request; sampled only in IDLE.
- req_operand  input  64  operand, latched when req is accepted.
- use_intr  input  1  latched with req; 1 = wait on interrupt, 0 = poll OP_DONE.
- busy  output  1  high from req acceptance until the cycle after res_valid/err.
- res_valid  output  1  one-cycle pulse: res_h/res_l valid.
- err  output  1  one-cycle pulse: timeout abort.
- res_h  output  64  RESULT_H captured.
- res_l  output  64  RESULT_L captured.
- m_sel  output  1  bus select.
- m_wr  output  1  1 = write, 0 = read.
- m_addr  output  16  bus address.
- m_dout  output  64  write data to slave (slave s_din).
- m_din  input  64  read data from slave (slave s_dout), combinational within the access cycle.
- interrupt  input  1  slave interrupt (OP_DONE[0] & INTR_EN[0]).

Behaviour:
- Register offsets from BASE_ADDR:
  - OP_START 0x00, OP_CLEAR 0x08, OP_DONE 0x10, INTR_EN 0x18
  - OPERAND 0x20, RESULT_H 0x28, RESULT_L 0x30
- Bus transactions:
  - Every access lasts exactly one cycle with m_sel=1.
  - Reads are captured on the rising edge that ends the access cycle.
  - At least one idle cycle follows every access; idle means m_sel=0, m_wr=0, m_addr=0, m_dout=0.
- Reset: state=IDLE; every output 0; internal counters 0. Reset mid-transaction aborts immediately with no further bus activity.
- FSM, one access per state, each followed by the idle gap:
  - IDLE: on req=1 latch operand and use_intr, set busy, go to W_OPND.
  - W_OPND: write OPERAND = operand.
  - W_INTR: write INTR_EN = {63'b0, use_intr}.
  - W_START: write OP_START = 64'd1; clear the wait counter.
  - WAIT, use_intr=1: exit when interrupt=1.
  - WAIT, use_intr=0: issue a read of OP_DONE every POLL_GAP+1 cycles; exit when the captured m_din[0]=1.
  - WAIT counter: increments every cycle in WAIT. Reaching TIMEOUT forces timeout path to W_CLR.
  - R_H: read RESULT_H into res_h.
  - R_L: read RESULT_L into res_l.
  - W_CLR: write OP_CLEAR = 64'd1.
  - W_CLR0: write OP_CLEAR = 64'd0 and OP_START = 64'd0, as two accesses with an idle gap between them.
  - FIN: pulse res_valid (normal) or err (timeout) for one cycle; busy drops the next cycle; return to IDLE.
- Hold and ordering rules:
  - res_h/res_l hold until the next successful R_H/R_L; on timeout they keep their previous values.
  - req while busy is ignored and not queued. req asserted in the same cycle FIN exits is ignored; it must be seen in IDLE.
  - If interrupt and the timeout limit coincide in WAIT, completion wins.
- Latency, operand accepted to WAIT entry: exactly 6 cycles (3 writes + 3 gaps).
- Width rules:
  - m_addr = BASE_ADDR + offset, modulo 2^16.
  - Wait counter is 16 bits and saturates at TIMEOUT.

Test Plan:
- Reset: reset_n=0 mid-WAIT -> all outputs 0 next cycle; no m_sel after release until a new req.
- Interrupt mode: req, operand=5, use_intr=1, slave model raises interrupt and returns RESULT_H=0, RESULT_L=120 -> access sequence writes OPERAND=5, INTR_EN=1, OP_START=1, reads RESULT_H then RESULT_L, writes OP_CLEAR=1, OP_CLEAR=0, OP_START=0; res_l=120, res_h=0, one res_valid pulse.
- Polling mode: operand=20, use_intr=0, POLL_GAP=4, OP_DONE bit0 set after 30 cycles -> OP_DONE reads exactly 5 cycles apart; res_l=64'h21C3677C82B40000.
- Timeout: TIMEOUT=16, slave never completes -> err pulses once; no RESULT reads; OP_CLEAR=1 still written; res_h/res_l unchanged.
- Request while busy: second req pulses during WAIT and on the FIN cycle -> ignored; exactly one transaction occurs.
- Boundary: BASE_ADDR=16'hFFF8 -> OPERAND access at m_addr=16'h0018 (wrap-around).
